// File: rtl/ds1302_txn_ctrl_if.sv
// Register-transaction bus for ds1302_txn_ctrl: request/response signals from
// the RTC control logic plus the SPI byte-master handshake and the CE/IO pins.
interface ds1302_txn_ctrl_if;
    logic        cmd_wr;
    logic        cmd_rd;
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        busy;
    logic        cmd_done;
    logic [7:0]  cmd_rdata;
    logic        cmd_err;
    logic        ce;
    logic        io_oe;
    logic        spi_cpol;
    logic        spi_cpha;
    logic [15:0] spi_clk_div;
    logic        spi_wr_req;
    logic        spi_wr_ack;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;

    // Sequencer side
    modport slave (
        input  cmd_wr, cmd_rd, cmd_addr, cmd_wdata, spi_wr_ack, spi_data_out,
        output busy, cmd_done, cmd_rdata, cmd_err, ce, io_oe,
        output spi_cpol, spi_cpha, spi_clk_div, spi_wr_req, spi_data_in
    );

    // Requester / SPI-master side
    modport master (
        output cmd_wr, cmd_rd, cmd_addr, cmd_wdata, spi_wr_ack, spi_data_out,
        input  busy, cmd_done, cmd_rdata, cmd_err, ce, io_oe,
        input  spi_cpol, spi_cpha, spi_clk_div, spi_wr_req, spi_data_in
    );
endinterface

// File: rtl/ds1302_txn_ctrl.sv
// DS1302 single-register transaction sequencer. Raises CE, sends the command
// byte and the data byte through the SPI byte master, honours CE setup/hold/
// idle times, and converts between DS1302 LSB-first and master MSB-first order.
// Optional: DS1302_ACK_TIMEOUT_EN adds an ack watchdog that aborts with cmd_err.
module ds1302_txn_ctrl #(
    parameter logic [15:0] SPI_CLK_DIV  = 16'd50,
    parameter int          CE_SETUP_CYC = 200,
    parameter int          CE_HOLD_CYC  = 20,
    parameter int          CE_IDLE_CYC  = 200
`ifdef DS1302_ACK_TIMEOUT_EN
    , parameter logic [15:0] ACK_TIMEOUT = 16'd4095
`endif
) (
    input  logic              sys_clk,
    input  logic              rst,
    ds1302_txn_ctrl_if.slave  bus
);

    // Last counter value in each timed state; 0 cycles collapses to one cycle.
    localparam logic [15:0] SETUP_LAST = (CE_SETUP_CYC == 0) ? 16'd0 : 16'(CE_SETUP_CYC - 1);
    localparam logic [15:0] HOLD_LAST  = (CE_HOLD_CYC  == 0) ? 16'd0 : 16'(CE_HOLD_CYC  - 1);
    localparam logic [15:0] IDLE_LAST  = (CE_IDLE_CYC  == 0) ? 16'd0 : 16'(CE_IDLE_CYC  - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_GAP1, S_DATA, S_HOLD, S_CEIDLE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rd_q, rd_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        req_q, req_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    function automatic logic [7:0] bitrev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Next-state, request pulses and data capture
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        req_d   = 1'b0;
        din_d   = din_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Write has priority when both strobes arrive together.
                if (bus.cmd_wr || bus.cmd_rd) begin
                    state_d = S_SETUP;
                    rd_d    = ~bus.cmd_wr;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                end
            end
            S_SETUP: begin
                if (cnt_q >= SETUP_LAST) begin
                    state_d = S_CMD;
                    req_d   = 1'b1;
                    din_d   = bitrev({1'b1, addr_q, rd_q});
                end
            end
            S_CMD: begin
                if (bus.spi_wr_ack) begin
                    state_d = S_GAP1;
                end
`ifdef DS1302_ACK_TIMEOUT_EN
                else if (cnt_q == ACK_TIMEOUT) begin
                    state_d = S_CEIDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            S_GAP1: begin
                // Two cycles: the master ignores a request right after its ack.
                if (cnt_q >= 16'd1) begin
                    state_d = S_DATA;
                    req_d   = 1'b1;
                    din_d   = rd_q ? 8'h00 : bitrev(wdata_q);
                end
            end
            S_DATA: begin
                if (bus.spi_wr_ack) begin
                    state_d = S_HOLD;
                    if (rd_q) rdata_d = bitrev(bus.spi_data_out);
                end
`ifdef DS1302_ACK_TIMEOUT_EN
                else if (cnt_q == ACK_TIMEOUT) begin
                    state_d = S_CEIDLE;
                    err_d   = 1'b1;
                end
`endif
            end
            S_HOLD: begin
                if (cnt_q >= HOLD_LAST) begin
                    state_d = S_CEIDLE;
                    done_d  = 1'b1;
                end
            end
            S_CEIDLE: begin
                if (cnt_q >= IDLE_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
    end

    // State and datapath registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            rd_q    <= 1'b0;
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
            req_q   <= 1'b0;
            din_q   <= 8'h00;
            rdata_q <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // CE and IO direction decode straight from the state register, so an
    // asynchronous reset drops CE immediately.
    assign bus.ce          = (state_q != S_IDLE) && (state_q != S_CEIDLE);
    assign bus.io_oe       = !((state_q == S_DATA) && rd_q);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.cmd_done    = done_q;
    assign bus.cmd_rdata   = rdata_q;
`ifdef DS1302_ACK_TIMEOUT_EN
    assign bus.cmd_err     = err_q;
`else
    assign bus.cmd_err     = 1'b0;
`endif
    assign bus.spi_cpol    = 1'b0;
    assign bus.spi_cpha    = 1'b0;
    assign bus.spi_clk_div = SPI_CLK_DIV;
    assign bus.spi_wr_req  = req_q;
    assign bus.spi_data_in = din_q;

endmodule

// File: tb/tb_ds1302_txn_ctrl.sv
// Self-checking bench for ds1302_txn_ctrl: directed plus randomized register
// transactions against a byte-level reference model and a simple SPI master.
module tb_ds1302_txn_ctrl;
    localparam int SETUP = 200;
    localparam int HOLD  = 20;
    localparam int IDLEC = 200;
    localparam int TMO   = 4095;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    ds1302_txn_ctrl_if bus();

    ds1302_txn_ctrl dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DS1302 is LSB-first, the master shifts MSB-first.
    function automatic logic [7:0] rev(input logic [7:0] x);
        return {<<{x}};
    endfunction

    // Pulse monitor
    int   req_cnt = 0, done_cnt = 0, err_cnt = 0, wide_cnt = 0;
    logic req_prev = 1'b0;
    always @(negedge sys_clk) begin
        if (bus.spi_wr_req === 1'b1) begin
            req_cnt <= req_cnt + 1;
            if (req_prev) wide_cnt <= wide_cnt + 1;
        end
        if (bus.cmd_done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.cmd_err === 1'b1) err_cnt <= err_cnt + 1;
        req_prev <= (bus.spi_wr_req === 1'b1);
    end

    task automatic tick;
        @(negedge sys_clk);
    endtask

    task automatic wait_req(input string tag, output int ce_cyc);
        int n = 0;
        ce_cyc = 0;
        while (bus.spi_wr_req !== 1'b1 && n < 1000) begin
            if (bus.ce === 1'b1) ce_cyc++;
            tick();
            n++;
        end
        if (bus.spi_wr_req !== 1'b1) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic send_ack(input logic [7:0] d);
        repeat ($urandom_range(2, 8)) tick();
        bus.spi_data_out = d;
        bus.spi_wr_ack   = 1'b1;
        tick();
        bus.spi_wr_ack   = 1'b0;
        bus.spi_data_out = 8'($urandom);
    endtask

    task automatic do_txn(input bit wr, input bit rd, input logic [5:0] addr,
                          input logic [7:0] wdata, input logic [7:0] rsp,
                          input bit inject, input bit abort);
        int rq0, dn0, n, cyc;
        bit isrd;
        logic [7:0] cmdb;
        rq0  = req_cnt;
        dn0  = done_cnt;
        isrd = !wr && rd;
        cmdb = {1'b1, addr, isrd};
        bus.cmd_wr = wr; bus.cmd_rd = rd; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
        tick();
        bus.cmd_wr = 0; bus.cmd_rd = 0;
        bus.cmd_addr = 6'($urandom); bus.cmd_wdata = 8'($urandom);
        if (inject) begin
            repeat (3) tick();
            bus.cmd_rd = 1'b1;
            tick();
            bus.cmd_rd = 1'b0;
        end
        wait_req("cmd_req", cyc);
        if (inject) cyc += 4;
        chk("setup_ce", 32'(cyc >= SETUP), 1);
        chk("cmd_byte", bus.spi_data_in, rev(cmdb));
        chk("cmd_oe", bus.io_oe, 1);
        send_ack(8'($urandom));
        wait_req("data_req", cyc);
        chk("data_byte", bus.spi_data_in, isrd ? 8'h00 : rev(wdata));
        chk("data_oe", bus.io_oe, !isrd);
        chk("data_ce", bus.ce, 1);
        if (abort) begin
            tick();
            rst = 1'b1;
            #1;
            chk("abort_ce", bus.ce, 0);
            chk("abort_req", bus.spi_wr_req, 0);
            chk("abort_busy", bus.busy, 0);
            tick();
            rst = 1'b0;
            exp_rdata = 8'h00;
            repeat (5) tick();
            chk("abort_nodone", done_cnt - dn0, 0);
            return;
        end
        send_ack(rsp);
        n = 0;
        while (bus.ce === 1'b1 && n < 1000) begin tick(); n++; end
        chk("hold", n, HOLD);
        chk("done_at_ce_fall", bus.cmd_done, 1);
        if (isrd) exp_rdata = rev(rsp);
        chk("rdata", bus.cmd_rdata, exp_rdata);
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin tick(); n++; end
        chk("ce_idle", n, IDLEC);
        repeat (20) tick();
        chk("rdata_held", bus.cmd_rdata, exp_rdata);
        chk("req_count", req_cnt - rq0, 2);
        chk("done_count", done_cnt - dn0, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_wr = 0; bus.cmd_rd = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0;
        bus.spi_wr_ack = 0; bus.spi_data_out = 0;
        repeat (3) tick();
        chk("rst_ce", bus.ce, 0);
        chk("rst_io_oe", bus.io_oe, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.cmd_done, 0);
        chk("rst_err", bus.cmd_err, 0);
        chk("rst_req", bus.spi_wr_req, 0);
        chk("rst_din", bus.spi_data_in, 8'h00);
        chk("rst_rdata", bus.cmd_rdata, 8'h00);
        chk("clk_div", bus.spi_clk_div, 16'd50);
        chk("cpol_cpha", {bus.spi_cpol, bus.spi_cpha}, 0);
        rst = 1'b0;
        tick();

        do_txn(1, 0, 6'h00, 8'h59, 8'h00, 0, 0);
        do_txn(0, 1, 6'h00, 8'h00, 8'h9A, 0, 0);
        do_txn(1, 0, 6'h07, 8'h80, 8'h00, 0, 0);
        do_txn(1, 1, 6'h15, 8'hC3, 8'h5A, 1, 0);
        do_txn(0, 1, 6'h21, 8'h00, 8'h33, 0, 1);
        do_txn(0, 1, 6'h21, 8'h00, 8'h3C, 0, 0);

        for (int k = 0; k < 10; k++) begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = !w || 1'($urandom_range(0, 1));
            do_txn(w, r, 6'($urandom), 8'($urandom), 8'($urandom), 0, 0);
        end

`ifdef DS1302_ACK_TIMEOUT_EN
        begin
            int cyc, n, dn0;
            dn0 = done_cnt;
            bus.cmd_wr = 1; bus.cmd_addr = 6'h0A; bus.cmd_wdata = 8'h11;
            tick();
            bus.cmd_wr = 0;
            wait_req("tmo_req", cyc);
            n = 0;
            while (bus.cmd_err !== 1'b1 && n < 5000) begin tick(); n++; end
            chk("tmo_latency", 32'(n >= TMO && n <= TMO + 1), 1);
            chk("tmo_ce", bus.ce, 0);
            chk("tmo_io_oe", bus.io_oe, 1);
            chk("tmo_rdata", bus.cmd_rdata, exp_rdata);
            n = 0;
            while (bus.busy === 1'b1 && n < 1000) begin tick(); n++; end
            chk("tmo_idle", n, IDLEC);
            repeat (5) tick();
            chk("tmo_nodone", done_cnt - dn0, 0);
            chk("tmo_err_once", err_cnt, 1);
        end
`else
        chk("err_never", err_cnt, 0);
`endif
        chk("req_width", wide_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
